// File: rtl/nuc_stream_matcher.sv
// nuc_stream_matcher: scans seq_len 2-bit nucleotides from a combinational-read
// memory starting at address 0. It slides a PLEN-nucleotide window over the
// stream and counts every pattern match, including overlapping ones. It also
// records the start address of the lowest-addressed match.
// Optional build macro NUC_MATCH_MASK_EN adds a per-nucleotide wildcard mask
// input (pattern_mask).
module nuc_stream_matcher #(
  parameter int AW   = 16,
  parameter int PLEN = 4
) (
  input  logic            clock,
  input  logic            reset_L,
  input  logic            start,
  input  logic [AW-1:0]   seq_len,
  input  logic [2*PLEN-1:0] pattern,
`ifdef NUC_MATCH_MASK_EN
  input  logic [PLEN-1:0] pattern_mask,
`endif
  output logic            mem_re,
  output logic [AW-1:0]   mem_addr,
  input  logic [1:0]      mem_data,
  output logic            busy,
  output logic            done,
  output logic            found,
  output logic [AW-1:0]   match_count,
  output logic [AW-1:0]   first_addr
);

  localparam int PW = 2 * PLEN;
  localparam int VW = $clog2(PLEN + 1);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [AW-1:0]   len_q, len_d;
  logic [PW-1:0]   pat_q, pat_d;
  logic [PW-1:0]   win_q, win_d;
  logic [VW-1:0]   vcnt_q, vcnt_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic            found_q, found_d;
  logic [AW-1:0]   first_q, first_d;
  logic            mem_re_q, mem_re_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [PW-1:0]   care;
  logic [PW-1:0]   win_next;
  logic            hit;

`ifdef NUC_MATCH_MASK_EN
  logic [PLEN-1:0] mask_q, mask_d;

  // Masked nucleotides are dropped from the compare by clearing their care bits.
  for (genvar gi = 0; gi < PLEN; gi++) begin : g_care
    assign care[2*gi+1:2*gi] = {2{~mask_q[gi]}};
  end
`else
  assign care = '1;
`endif

  assign win_next = {win_q[PW-3:0], mem_data};
  // A match needs PLEN valid nucleotides once the current one is shifted in.
  assign hit      = (vcnt_q >= VW'(PLEN - 1)) && (((win_next ^ pat_q) & care) == '0);

  // Next-state and result-update logic for the scan FSM.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    len_d    = len_q;
    pat_d    = pat_q;
    win_d    = win_q;
    vcnt_d   = vcnt_q;
    cnt_d    = cnt_q;
    found_d  = found_q;
    first_d  = first_q;
    mem_re_d = mem_re_q;
    busy_d   = busy_q;
    done_d   = done_q;
`ifdef NUC_MATCH_MASK_EN
    mask_d   = mask_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          len_d   = seq_len;
          pat_d   = pattern;
`ifdef NUC_MATCH_MASK_EN
          mask_d  = pattern_mask;
`endif
          win_d   = '0;
          vcnt_d  = '0;
          cnt_d   = '0;
          found_d = 1'b0;
          first_d = '0;
          addr_d  = '0;
          if (seq_len != '0) begin
            state_d  = S_SCAN;
            mem_re_d = 1'b1;
            busy_d   = 1'b1;
            done_d   = 1'b0;
          end else begin
            state_d  = S_DONE;
            mem_re_d = 1'b0;
            busy_d   = 1'b0;
            done_d   = 1'b1;
          end
        end
      end
      S_SCAN: begin
        win_d = win_next;
        if (vcnt_q < VW'(PLEN)) vcnt_d = vcnt_q + VW'(1);
        if (hit) begin
          if (cnt_q != '1) cnt_d = cnt_q + AW'(1);
          if (!found_q) begin
            found_d = 1'b1;
            first_d = addr_q - AW'(PLEN - 1);
          end
        end
        if (addr_q == len_q - AW'(1)) begin
          // Address returns to 0 so mem_addr is 0 whenever mem_re is low.
          state_d  = S_DONE;
          addr_d   = '0;
          mem_re_d = 1'b0;
          busy_d   = 1'b0;
          done_d   = 1'b1;
        end else begin
          addr_d = addr_q + AW'(1);
        end
      end
      default: begin
        state_d  = S_IDLE;
        mem_re_d = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        addr_d   = '0;
      end
    endcase
  end

  // State, captured configuration, window and registered outputs.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      len_q    <= '0;
      pat_q    <= '0;
      win_q    <= '0;
      vcnt_q   <= '0;
      cnt_q    <= '0;
      found_q  <= 1'b0;
      first_q  <= '0;
      mem_re_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef NUC_MATCH_MASK_EN
      mask_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      pat_q    <= pat_d;
      win_q    <= win_d;
      vcnt_q   <= vcnt_d;
      cnt_q    <= cnt_d;
      found_q  <= found_d;
      first_q  <= first_d;
      mem_re_q <= mem_re_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef NUC_MATCH_MASK_EN
      mask_q   <= mask_d;
`endif
    end
  end

  assign mem_re      = mem_re_q;
  assign mem_addr    = addr_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign found       = found_q;
  assign match_count = cnt_q;
  assign first_addr  = first_q;

endmodule

// File: tb/tb_nuc_stream_matcher.sv
// Self-checking bench for nuc_stream_matcher (PLEN=4): a scoreboard of
// expected read addresses and final results, filled at start and drained as
// the DUT reads memory and raises done.
module tb_nuc_stream_matcher;
  localparam int AW = 16;
  localparam int PLEN = 4;

  typedef struct {
    logic [AW-1:0] cnt;
    logic          fnd;
    logic [AW-1:0] first;
    int            done_cyc;
  } res_t;

  logic          clock = 1'b0;
  logic          reset_L;
  logic          start;
  logic [AW-1:0] seq_len;
  logic [7:0]    pattern;
`ifdef NUC_MATCH_MASK_EN
  logic [3:0]    pattern_mask;
`endif
  logic          mem_re;
  logic [AW-1:0] mem_addr;
  logic [1:0]    mem_data;
  logic          busy, done, found;
  logic [AW-1:0] match_count, first_addr;

  // Second instance with AW=3 fed an all-A memory.
  logic          start_b;
  logic [2:0]    seq_len_b;
  logic [7:0]    pattern_b;
  logic          mem_re_b;
  logic [2:0]    mem_addr_b;
  logic [1:0]    mem_data_b;
  logic          busy_b, done_b, found_b;
  logic [2:0]    match_count_b, first_addr_b;

  logic [1:0]    mem [0:15];
  res_t          res_q[$];
  logic [AW-1:0] addr_exp_q[$];
  int            errors = 0;
  int            checks = 0;

  always #5 clock = ~clock;
  assign mem_data   = mem[mem_addr[3:0]];
  assign mem_data_b = 2'b00;

  nuc_stream_matcher #(.AW(AW), .PLEN(PLEN)) dut (
    .clock(clock), .reset_L(reset_L), .start(start), .seq_len(seq_len),
    .pattern(pattern),
`ifdef NUC_MATCH_MASK_EN
    .pattern_mask(pattern_mask),
`endif
    .mem_re(mem_re), .mem_addr(mem_addr), .mem_data(mem_data),
    .busy(busy), .done(done), .found(found),
    .match_count(match_count), .first_addr(first_addr)
  );

  nuc_stream_matcher #(.AW(3), .PLEN(PLEN)) dut_b (
    .clock(clock), .reset_L(reset_L), .start(start_b), .seq_len(seq_len_b),
    .pattern(pattern_b),
`ifdef NUC_MATCH_MASK_EN
    .pattern_mask(4'b0000),
`endif
    .mem_re(mem_re_b), .mem_addr(mem_addr_b), .mem_data(mem_data_b),
    .busy(busy_b), .done(done_b), .found(found_b),
    .match_count(match_count_b), .first_addr(first_addr_b)
  );

  // Loads 8 nucleotides, lowest address in the top bits.
  task automatic set_mem(input logic [15:0] v);
    for (int i = 0; i < 16; i++) mem[i] = 2'b00;
    for (int i = 0; i < 8; i++) mem[i] = v[15-2*i -: 2];
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if ({mem_re, mem_addr, busy, done, found, match_count, first_addr} !== '0)
      begin
      errors++;
      $display("FAIL %s: re=%0b addr=%0d busy=%0b done=%0b found=%0b cnt=%0d first=%0d, all required 0",
               tag, mem_re, mem_addr, busy, done, found, match_count, first_addr);
    end
  endtask

  // Pushes expectations and pulses start across one rising edge (edge 0).
  task automatic start_scan(input int len, input logic [7:0] pat, input logic [3:0] msk,
                            input int exp_cnt, input logic exp_fnd, input int exp_first);
    res_t r;
    r.cnt = AW'(exp_cnt); r.fnd = exp_fnd; r.first = AW'(exp_first); r.done_cyc = len + 1;
    res_q.push_back(r);
    for (int a = 0; a < len; a++) addr_exp_q.push_back(AW'(a));
    seq_len = AW'(len);
    pattern = pat;
`ifdef NUC_MATCH_MASK_EN
    pattern_mask = msk;
`else
    if (msk != 4'b0000) $display("note: mask ignored in this build");
`endif
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
  endtask

  // Drains the scoreboard: one read address per mem_re cycle, results at done.
  task automatic wait_done(input string tag, input int len);
    int   cyc = 0;
    bit   got = 0;
    res_t r;
    while (!got && cyc < len + 20) begin
      @(negedge clock);
      cyc++;
      if (cyc == 1) begin
        checks++;
        if (match_count !== '0 || found !== 1'b0) begin
          errors++;
          $display("FAIL %s_cleared: cnt=%0d found=%0b required 0/0", tag, match_count, found);
        end
      end
      if (mem_re) begin
        checks++;
        if (addr_exp_q.size() == 0) begin
          errors++;
          $display("FAIL %s_extra_read: addr=%0d in cycle %0d, required no read", tag, mem_addr, cyc);
        end else begin
          if (mem_addr !== addr_exp_q[0] || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s_addr: addr=%0d busy=%0b required addr=%0d busy=1",
                     tag, mem_addr, busy, addr_exp_q[0]);
          end
          void'(addr_exp_q.pop_front());
        end
      end else if (mem_addr !== '0) begin
        checks++;
        errors++;
        $display("FAIL %s_idle_addr: addr=%0d with mem_re=0, required 0", tag, mem_addr);
      end
      if (done) begin
        got = 1;
        r = res_q.pop_front();
        checks++;
        if (match_count !== r.cnt || found !== r.fnd || first_addr !== r.first ||
            cyc != r.done_cyc || busy !== 1'b0 || addr_exp_q.size() != 0) begin
          errors++;
          $display("FAIL %s_result: cnt=%0d found=%0b first=%0d done_cyc=%0d left=%0d required cnt=%0d found=%0b first=%0d done_cyc=%0d left=0",
                   tag, match_count, found, first_addr, cyc, addr_exp_q.size(),
                   r.cnt, r.fnd, r.first, r.done_cyc);
        end else
          $display("%s: cnt=%0d found=%0b first=%0d done_cyc=%0d", tag, match_count, found, first_addr, cyc);
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: done not seen in %0d cycles, required by cycle %0d", tag, cyc, len + 1);
      res_q.delete();
      addr_exp_q.delete();
    end
  endtask

  task automatic test_reset();
    reset_L = 1'b0; start = 1'b0; start_b = 1'b0;
    seq_len = '0; pattern = '0; seq_len_b = '0; pattern_b = '0;
`ifdef NUC_MATCH_MASK_EN
    pattern_mask = '0;
`endif
    repeat (3) @(negedge clock);
    check_all_zero("reset");
    reset_L = 1'b1;
    @(negedge clock);
    check_all_zero("post_reset_idle");
  endtask

  task automatic test_base_match();
    set_mem(16'h1B1B);
    start_scan(8, 8'h1B, 4'b0, 2, 1'b1, 0);
    wait_done("base", 8);
  endtask

  task automatic test_restart_from_done();
    start_scan(8, 8'h6C, 4'b0, 1, 1'b1, 1);
    wait_done("restart", 8);
  endtask

  task automatic test_overlap();
    set_mem(16'h0000);
    start_scan(6, 8'h00, 4'b0, 3, 1'b1, 0);
    wait_done("overlap", 6);
  endtask

  task automatic test_short_empty();
    start_scan(3, 8'h00, 4'b0, 0, 1'b0, 0);
    wait_done("short", 3);
    start_scan(0, 8'h00, 4'b0, 0, 1'b0, 0);
    wait_done("empty", 0);
  endtask

  task automatic test_reset_mid_scan();
    set_mem(16'h1B1B);
    start_scan(8, 8'h1B, 4'b0, 2, 1'b1, 0);
    repeat (3) @(negedge clock);
    checks++;
    if (mem_re !== 1'b1 || mem_addr !== AW'(2)) begin
      errors++;
      $display("FAIL midscan_addr: re=%0b addr=%0d required re=1 addr=2", mem_re, mem_addr);
    end
    reset_L = 1'b0;
    #1 check_all_zero("midscan_reset");
    res_q.delete();
    addr_exp_q.delete();
    @(negedge clock);
    check_all_zero("midscan_reset_held");
    reset_L = 1'b1;
    @(negedge clock);
    check_all_zero("midscan_idle");
    start_scan(8, 8'h1B, 4'b0, 2, 1'b1, 0);
    wait_done("after_reset", 8);
  endtask

  task automatic test_mask();
    set_mem(16'h1B3B);
`ifdef NUC_MATCH_MASK_EN
    start_scan(8, 8'h1B, 4'b0100, 2, 1'b1, 0);
`else
    start_scan(8, 8'h1B, 4'b0100, 1, 1'b1, 0);
`endif
    wait_done("mask", 8);
  endtask

  task automatic run_b(input string tag, input bit do_force, input int exp_cnt);
    int cyc = 0;
    seq_len_b = 3'd7; pattern_b = 8'h00; start_b = 1'b1;
    @(posedge clock);
    #1 start_b = 1'b0;
    if (do_force) begin
      repeat (2) @(negedge clock);
      force dut_b.cnt_q = 3'd7;
      @(negedge clock);
      release dut_b.cnt_q;
      cyc = 3;
    end
    while (!done_b && cyc < 30) begin
      @(negedge clock);
      cyc++;
    end
    checks++;
    if (!done_b || match_count_b !== 3'(exp_cnt) || found_b !== 1'b1 ||
        first_addr_b !== 3'd0 || cyc != 8) begin
      errors++;
      $display("FAIL %s: done=%0b cnt=%0d found=%0b first=%0d cyc=%0d required done=1 cnt=%0d found=1 first=0 cyc=8",
               tag, done_b, match_count_b, found_b, first_addr_b, cyc, exp_cnt);
    end else
      $display("%s: cnt=%0d", tag, match_count_b);
  endtask

  task automatic test_saturation();
    run_b("aw3_all_a", 1'b0, 4);
    run_b("aw3_saturate", 1'b1, 7);
  endtask

  initial begin
    test_reset();
    test_base_match();
    test_restart_from_done();
    test_overlap();
    test_short_empty();
    test_reset_mid_scan();
    test_mask();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nuc_stream_matcher.md
Name: nuc_stream_matcher

Overview:
- Scans a nucleotide sequence held in the nucleotide memory, one 2-bit nucleotide per cycle.
- Compares a sliding window of the last PLEN nucleotides against a PLEN-nucleotide pattern.
- Counts all matches, including overlapping ones, and reports the address of the first match.
- Sits directly downstream of the nucleotide memory: drives its read enable and address, and consumes its combinational Data output.

Parameters:
- AW, 16: nucleotide memory address width.
- PLEN, 4: pattern length in nucleotides (≥2).

Ports:
- clock  input  1  system clock, posedge.
- reset_L  input  1  asynchronous, active-low reset.
- start  input  1  begin scan; sampled in IDLE or DONE only.
- seq_len  input  AW  number of nucleotides to scan from address 0; captured at start.
- pattern  input  2*PLEN  pattern. Bits [2*PLEN-1:2*PLEN-2] are the nucleotide expected at the lowest address. Captured at start.
- mem_re  output  1  memory read enable.
- mem_addr  output  AW  memory address.
- mem_data  input  2  nucleotide returned by memory, valid in the same cycle as mem_addr/mem_re (combinational read).
- busy  output  1  high in SCAN.
- done  output  1  high in DONE.
- found  output  1  at least one match seen.
- match_count  output  AW  number of matches, saturating at all-ones.
- first_addr  output  AW  start address of the lowest-addressed match; 0 if none.

Behaviour:
- Reset: async on reset_L=0. State IDLE; all outputs 0; window, counters and captured registers cleared. Reset mid-scan aborts immediately; no partial results retained.
- Encoding: A=00, C=01, G=10, T=11.
- States: IDLE, SCAN, DONE.
- IDLE:
  - start=1 and seq_len≠0: capture seq_len and pattern; clear window, valid count, match_count, found, first_addr; go to SCAN.
  - start=1 and seq_len=0: clear results; go straight to DONE without asserting mem_re.
- SCAN: mem_re=1, mem_addr=addr (addr starts at 0).
  - Each cycle: window_next = {window[2*PLEN-3:0], mem_data}; valid count increments, saturating at PLEN.
  - A match occurs when the valid count before the shift is ≥PLEN-1 and window_next==pattern. It is evaluated combinationally in the same cycle and registered at the clock edge.
  - On match: match_count += 1 (saturating); if found=0, first_addr ← addr-(PLEN-1) and found ← 1.
  - addr==seq_len-1: register the final compare, go to DONE, drive mem_re=0.
  - Otherwise addr increments.
- DONE: done=1; results held stable. start=1 restarts exactly as from IDLE (results cleared on that edge). No automatic return to IDLE.
- start is ignored in SCAN.
- Latency: start sampled at edge 0 → addresses 0..seq_len-1 read in cycles 1..seq_len → done first high in cycle seq_len+1.
- Boundaries:
  - seq_len<PLEN: no match possible; count stays 0.
  - Overlapping matches are all counted.
  - mem_addr never exceeds seq_len-1 and is 0 whenever mem_re=0.
  - seq_len=2^AW-1 is the maximum scanned length.

Optional Feature:
- Macro: NUC_MATCH_MASK_EN.
- Defined: adds input pattern_mask [PLEN-1:0], captured at start. Bit i=1 makes pattern nucleotide bits [2i+1:2i] a wildcard, i.e. excluded from the compare.
- Undefined: the port is absent and all PLEN nucleotides are compared.

Test Plan (PLEN=4):
- Base match: memory ACGTACGT, seq_len=8, pattern=8'h1B (ACGT), start pulse at cycle 0 → mem_addr 0..7 in cycles 1..8; done high in cycle 9; match_count=2; found=1; first_addr=0.
- Overlap: memory AAAAAA, seq_len=6, pattern=8'h00 → match_count=3, first_addr=0, done in cycle 7.
- Short and empty sequences:
  - seq_len=3 → match_count=0, found=0, done in cycle 4.
  - seq_len=0 → done in cycle 1; mem_re never asserted.
- Reset mid-scan: reset_L low in cycle 3 of the base-match scan → all outputs 0 immediately, state IDLE. A fresh start then reproduces the base-match result.
- Restart from DONE and saturation:
  - start in DONE with pattern CGTA (8'h6C) on the base memory → results cleared, then match_count=1, first_addr=1.
  - With AW=3, memory all A, seq_len=7, pattern=8'h00 → match_count=4. AW=3 caps match_count at 7 and seq_len at 7, so saturation itself cannot occur here. Exercise it directly by forcing match_count to its maximum and driving a further match → value holds.
- Mask (NUC_MATCH_MASK_EN): memory ACGTATGT, pattern ACGT, pattern_mask=4'b0100 → match_count=2, first_addr=0. Macro undefined, same stimulus → match_count=1.
